// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction field layout, addressing mode
// and the fetch-stage state encoding.
package sisc_pkg;

    localparam int unsigned PC_W_DEF = 16;
    localparam int unsigned IR_W_DEF = 32;

    localparam logic [3:0] NOOP   = 4'h0;
    localparam logic [3:0] ALU_OP = 4'h1;
    localparam logic [3:0] BRA    = 4'h4;
    localparam logic [3:0] BRR    = 4'h5;
    localparam logic [3:0] BNE    = 4'h6;
    localparam logic [3:0] BNR    = 4'h7;
    localparam logic [3:0] LOD    = 4'h8;
    localparam logic [3:0] STR    = 4'h9;
    localparam logic [3:0] SWP    = 4'ha;
    localparam logic [3:0] HLT    = 4'hf;

    // mm value selecting immediate addressing
    localparam logic [3:0] AM_IMM = 4'h8;

    localparam int unsigned FIELD_W    = 4;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned OPCODE_LSB = 28;
    localparam int unsigned MM_LSB     = 24;
    localparam int unsigned RD_LSB     = 20;
    localparam int unsigned RS_LSB     = 16;
    localparam int unsigned RT_LSB     = 12;
    localparam int unsigned IMM_LSB    = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sisc_pc_next.sv
// Next-PC selection: sequential, absolute or PC-relative target, all modulo 2^PC_W.
module sisc_pc_next
    import sisc_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [IMM_W-1:0] imm,
    input  logic             pc_sel,
    input  logic             br_sel,
    output logic [PC_W-1:0]  pc_next
);

    logic [PC_W-1:0] imm_ext;

    // imm is unsigned; wrap-around of the add yields backward branches
    assign imm_ext = PC_W'(imm);

    always_comb begin
        pc_next = pc + PC_W'(1);
        if (pc_sel) begin
            pc_next = br_sel ? imm_ext : (pc + imm_ext);
        end
    end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction-fetch stage: PC, instruction register and a req/ack fetch
// FSM that can drain a request cancelled by pc_rst.
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter int unsigned     IR_W     = IR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_f,
    input  logic                pc_rst,
    input  logic                pc_write,
    input  logic                pc_sel,
    input  logic                br_sel,
    input  logic                ir_load,
    output logic [PC_W-1:0]     im_addr,
    output logic                im_req,
    input  logic                im_ack,
    input  logic [IR_W-1:0]     im_rdata,
    output logic                fetch_stall,
    output logic [IR_W-1:0]     ir,
    output logic [FIELD_W-1:0]  opcode,
    output logic [FIELD_W-1:0]  mm,
    output logic [FIELD_W-1:0]  rd,
    output logic [FIELD_W-1:0]  rs,
    output logic [FIELD_W-1:0]  rt,
    output logic [IMM_W-1:0]    imm,
    output logic [PC_W-1:0]     pc
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_target;
    logic [PC_W-1:0] im_addr_q, im_addr_d;
    logic            im_req_q, im_req_d;
    logic [IR_W-1:0] ir_q, ir_d;

    sisc_pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc      (pc_q),
        .imm     (ir_q[IMM_LSB +: IMM_W]),
        .pc_sel  (pc_sel),
        .br_sel  (br_sel),
        .pc_next (pc_target)
    );

    always_comb begin
        pc_d = pc_q;
        if (pc_rst) begin
            pc_d = RESET_PC;
        end else if (pc_write) begin
            pc_d = pc_target;
        end
    end

    always_comb begin
        state_d   = state_q;
        im_addr_d = im_addr_q;
        im_req_d  = im_req_q;
        ir_d      = ir_q;
        unique case (state_q)
            StIdle: begin
                if (ir_load) begin
                    im_addr_d = pc_q;
                    im_req_d  = 1'b1;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (im_ack) begin
                    // a PC clear in the ack cycle cancels the instruction as well
                    ir_d     = pc_rst ? '0 : im_rdata;
                    im_req_d = 1'b0;
                    state_d  = StIdle;
                end else if (pc_rst) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (im_ack) begin
                    ir_d     = '0;
                    im_req_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            im_addr_q <= '0;
            im_req_q  <= 1'b0;
            ir_q      <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            im_addr_q <= im_addr_d;
            im_req_q  <= im_req_d;
            ir_q      <= ir_d;
        end
    end

    assign fetch_stall = (state_q != StIdle);
    assign im_addr     = im_addr_q;
    assign im_req      = im_req_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign opcode      = ir_q[OPCODE_LSB +: FIELD_W];
    assign mm          = ir_q[MM_LSB +: FIELD_W];
    assign rd          = ir_q[RD_LSB +: FIELD_W];
    assign rs          = ir_q[RS_LSB +: FIELD_W];
    assign rt          = ir_q[RT_LSB +: FIELD_W];
    assign imm         = ir_q[IMM_LSB +: IMM_W];

endmodule

// File: tb/tb_sisc_fetch.sv
// Scoreboard bench for sisc_fetch: directed scenarios plus random traffic, all
// checked against a transaction-level model of PC and fetch behaviour.
module tb_sisc_fetch;

    logic        clk = 1'b0;
    logic        rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load, im_ack;
    logic [31:0] im_rdata;
    logic [15:0] im_addr, imm, pc;
    logic        im_req, fetch_stall;
    logic [31:0] ir;
    logic [3:0]  opcode, mm, rd, rs, rt;

    sisc_fetch u_dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .pc_rst      (pc_rst),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .br_sel      (br_sel),
        .ir_load     (ir_load),
        .im_addr     (im_addr),
        .im_req      (im_req),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .fetch_stall (fetch_stall),
        .ir          (ir),
        .opcode      (opcode),
        .mm          (mm),
        .rd          (rd),
        .rs          (rs),
        .rt          (rt),
        .imm         (imm),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pc;
        bit          busy;
        int          addr;
        logic [31:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Model: PC as an integer mod 65536, one outstanding fetch with a cancel flag
    int          m_pc   = 0;
    bit          m_busy = 1'b0;
    bit          m_kill = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_ir   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        pc_rst   = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        ir_load  = 1'b0;
        im_ack   = 1'b0;
        im_rdata = '0;
    endtask

    // One clock of stimulus; the model predicts the state after the next edge.
    task automatic cycle(input bit pcr, input bit pw, input bit ps, input bit bs,
                         input bit irl, input bit ack, input logic [31:0] rdat);
        int   pc_old;
        int   bimm;
        exp_t e;
        @(negedge clk);
        pc_rst   = pcr;
        pc_write = pw;
        pc_sel   = ps;
        br_sel   = bs;
        ir_load  = irl;
        im_ack   = ack;
        im_rdata = rdat;
        pc_old   = m_pc;
        bimm     = int'(m_ir[15:0]);
        if (pcr)           m_pc = 0;
        else if (pw && !ps) m_pc = (m_pc + 1) % 65536;
        else if (pw && bs)  m_pc = bimm;
        else if (pw)        m_pc = (m_pc + bimm) % 65536;
        if (!m_busy) begin
            if (irl) begin
                m_busy = 1'b1;
                m_kill = 1'b0;
                m_addr = pc_old;
            end
        end else if (ack) begin
            m_ir   = (m_kill || pcr) ? 32'h0 : rdat;
            m_busy = 1'b0;
        end else if (pcr) begin
            m_kill = 1'b1;
        end
        e.pc   = m_pc;
        e.busy = m_busy;
        e.addr = m_addr;
        e.ir   = m_ir;
        exp_q.push_back(e);
    endtask

    task automatic load_ir(input logic [31:0] val);
        cycle(0, 0, 0, 0, 1, 0, '0);
        cycle(0, 0, 0, 0, 0, 1, val);
    endtask

    task automatic set_pc(input logic [15:0] val);
        load_ir({16'h0000, val});
        cycle(0, 1, 1, 1, 0, 0, '0);
    endtask

    task automatic probe();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares DUT outputs after each edge that has a pending expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", {16'h0, pc}, e.pc);
                chk("fetch_stall", {31'h0, fetch_stall}, {31'h0, e.busy});
                chk("im_req", {31'h0, im_req}, {31'h0, e.busy});
                if (e.busy) chk("im_addr", {16'h0, im_addr}, e.addr);
                chk("ir", ir, e.ir);
                chk("opcode", {28'h0, opcode}, {28'h0, e.ir[31:28]});
                chk("mm", {28'h0, mm}, {28'h0, e.ir[27:24]});
                chk("rd", {28'h0, rd}, {28'h0, e.ir[23:20]});
                chk("rs", {28'h0, rs}, {28'h0, e.ir[19:16]});
                chk("rt", {28'h0, rt}, {28'h0, e.ir[15:12]});
                chk("imm", {16'h0, imm}, {16'h0, e.ir[15:0]});
            end
        end
    end

    initial begin
        rst_f = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_f = 1'b1;
        #1;
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_req", {31'h0, im_req}, 32'h0);
        chk("rst_stall", {31'h0, fetch_stall}, 32'h0);

        // Asynchronous reset in the middle of a fetch from PC=0x0042
        set_pc(16'h0042);
        cycle(0, 0, 0, 0, 1, 0, '0);
        probe();
        chk("pre_rst_pc", {16'h0, pc}, 32'h42);
        @(negedge clk);
        #1;
        drive_idle();
        rst_f = 1'b0;
        #1;
        chk("arst_pc", {16'h0, pc}, 32'h0);
        chk("arst_ir", ir, 32'h0);
        chk("arst_req", {31'h0, im_req}, 32'h0);
        chk("arst_stall", {31'h0, fetch_stall}, 32'h0);
        chk("arst_addr", {16'h0, im_addr}, 32'h0);
        m_pc   = 0;
        m_busy = 1'b0;
        m_kill = 1'b0;
        m_ir   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_f = 1'b1;

        // Fetch at PC=5 with sequential increment, ack after wait states
        set_pc(16'h0005);
        cycle(0, 1, 0, 0, 1, 0, '0);
        probe();
        chk("fetch_addr", {16'h0, im_addr}, 32'h5);
        chk("fetch_pc", {16'h0, pc}, 32'h6);
        cycle(0, 0, 0, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, 0, 1, 32'h8123_4567);
        probe();
        chk("dec_opcode", {28'h0, opcode}, 32'h8);
        chk("dec_mm", {28'h0, mm}, 32'h1);
        chk("dec_imm", {16'h0, imm}, 32'h4567);
        chk("fetch_done", {31'h0, fetch_stall}, 32'h0);

        // Absolute and relative branches from PC=0x0010
        set_pc(16'h0010);
        load_ir(32'h0000_0200);
        cycle(0, 1, 1, 1, 0, 0, '0);
        probe();
        chk("br_abs", {16'h0, pc}, 32'h0200);
        set_pc(16'h0010);
        load_ir(32'h0000_fffe);
        cycle(0, 1, 1, 0, 0, 0, '0);
        probe();
        chk("br_rel_back", {16'h0, pc}, 32'h000e);

        // Sequential wrap at the top of the address space
        set_pc(16'hffff);
        cycle(0, 1, 0, 0, 0, 0, '0);
        probe();
        chk("pc_wrap", {16'h0, pc}, 32'h0);

        // pc_rst during WAIT: request drains, fetched HLT is discarded
        set_pc(16'h0020);
        cycle(0, 0, 0, 0, 1, 0, '0);
        cycle(1, 0, 0, 0, 0, 0, '0);
        probe();
        chk("drain_req", {31'h0, im_req}, 32'h1);
        cycle(0, 0, 0, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, 0, 1, 32'hf000_0000);
        probe();
        chk("drain_ir", ir, 32'h0);
        chk("drain_no_hlt", {28'h0, opcode}, 32'h0);
        chk("drain_req_drop", {31'h0, im_req}, 32'h0);

        // ir_load while WAIT is ignored
        set_pc(16'h0030);
        cycle(0, 1, 0, 0, 1, 0, '0);
        cycle(0, 0, 0, 0, 1, 0, '0);
        probe();
        chk("ign_addr", {16'h0, im_addr}, 32'h30);
        cycle(0, 0, 0, 0, 1, 1, 32'h1234_0001);
        probe();
        chk("ign_idle", {31'h0, fetch_stall}, 32'h0);

        // Random traffic; memory acks only outstanding requests
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(15) == 0, $urandom_range(2) == 0, $urandom_range(1) == 1,
                  $urandom_range(1) == 1, $urandom_range(3) == 0,
                  m_busy && ($urandom_range(2) == 0), $urandom);
        end

        @(negedge clk);
        drive_idle();
        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
